// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserialiser and
// a data-available / read-acknowledge output queue.
// Build option: define PS2_FIFO_EN for a FIFO_DEPTH-entry circular buffer;
// otherwise a single holding register is used.
module ps2_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       mclk25,
  input  logic       reset_in_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       do_read,
  output logic [7:0] scan_code,
  output logic       scan_dav,
  output logic       scan_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN) + 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {StIdle, StData, StParity, StStop, StCheck} state_e;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_filt_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             filt_flip, fall, data_s;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             parity_q, parity_d;
  logic             stop_q, stop_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             push, frame_err, ovf, pop;
  logic             err_q;

  // Two-flop synchronisers; bit [1] is the synchronised level
  always_ff @(posedge mclk25) begin
    if (!reset_in_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign data_s    = data_sync_q[1];
  assign filt_flip = (clk_sync_q[1] != clk_filt_q) && (filt_cnt_q == FiltW'(FILTER_LEN - 1));
  assign fall      = filt_flip & clk_filt_q;

  // Clock deglitch: level must differ for FILTER_LEN samples before it is accepted
  always_ff @(posedge mclk25) begin
    if (!reset_in_n) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_sync_q[1] == clk_filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_flip) begin
      clk_filt_q <= clk_sync_q[1];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FiltW'(1);
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge mclk25) begin
    if (!reset_in_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      stop_q    <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      stop_q    <= stop_d;
      tmo_q     <= tmo_d;
    end
  end

  // Frame FSM next state, push strobe and frame error strobe
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    stop_d    = stop_q;
    tmo_d     = tmo_q;
    push      = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (fall) begin
          if (!data_s) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      StData, StParity, StStop: begin
        if (fall) begin
          tmo_d = '0;
          if (state_q == StData) begin
            shreg_d   = {data_s, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = StParity;
          end else if (state_q == StParity) begin
            parity_d = data_s;
            state_d  = StStop;
          end else begin
            stop_d  = data_s;
            state_d = StCheck;
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          // Device stalled mid-frame: abandon it
          frame_err = 1'b1;
          state_d   = StIdle;
          tmo_d     = '0;
          bit_cnt_d = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StCheck: begin
        state_d = StIdle;
        if ((^shreg_q ^ parity_q) && stop_q) push = 1'b1;
        else                                  frame_err = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef PS2_FIFO_EN
  localparam int unsigned Aw = $clog2(FIFO_DEPTH);

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [Aw:0] wptr_q, rptr_q;
  logic        empty, full, wr;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign pop   = do_read & ~empty;
  // A pop frees the slot in the same cycle, so push on full+pop is accepted
  assign wr    = push & (~full | pop);
  assign ovf   = push & full & ~pop;

  // Circular buffer storage and pointers
  always_ff @(posedge mclk25) begin
    if (!reset_in_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
    end else begin
      if (wr) begin
        mem_q[wptr_q[Aw-1:0]] <= shreg_q;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign scan_code = mem_q[rptr_q[Aw-1:0]];
  assign scan_dav  = ~empty;
`else
  logic [7:0]  hold_q;
  logic        dav_q;
  logic [31:0] unused_fifo_depth;

  assign unused_fifo_depth = FIFO_DEPTH;
  assign pop = do_read & dav_q;
  assign ovf = push & dav_q & ~pop;

  // Single holding register: a push alongside a pop replaces the head
  always_ff @(posedge mclk25) begin
    if (!reset_in_n) begin
      hold_q <= 8'h00;
      dav_q  <= 1'b0;
    end else if (push && (!dav_q || pop)) begin
      hold_q <= shreg_q;
      dav_q  <= 1'b1;
    end else if (pop) begin
      dav_q  <= 1'b0;
    end
  end

  assign scan_code = hold_q;
  assign scan_dav  = dav_q;
`endif

  // Error pulse register; frame errors and overflow never share a cycle
  always_ff @(posedge mclk25) begin
    if (!reset_in_n) err_q <= 1'b0;
    else             err_q <= frame_err | ovf;
  end

  assign scan_err = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: stimulus pushes expected bytes/errors, a
// monitor pops and compares whenever the receiver pops a byte or flags an error.
module tb_ps2_rx;

`ifdef PS2_FIFO_EN
  localparam int Depth = 4;
`else
  localparam int Depth = 1;
`endif
  // stop-bit pin edge -> filtered fall: 2 sync + (FILTER_LEN-1) filter cycles,
  // then 2 cycles to scan_dav
  localparam int DavLat = 2 + (8 - 1) + 2;

  logic       mclk25 = 1'b0;
  logic       reset_in_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       do_read;
  logic       rd_tie = 1'b0;
  logic       rd_man = 1'b0;
  logic [7:0] scan_code;
  logic       scan_dav;
  logic       scan_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_err = 0;
  int obs_err = 0;
  int last_fall_cyc = 0;
  int last_err_cyc = 0;
  int last_rise_cyc = 0;
  int last_run_len = 0;
  int dav_run = 0;
  logic dav_prev = 1'b0;
  logic err_prev = 1'b0;
  logic [7:0] exp_q[$];

  assign do_read = rd_tie ? scan_dav : rd_man;

  ps2_rx dut (
    .mclk25     (mclk25),
    .reset_in_n (reset_in_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .do_read    (do_read),
    .scan_code  (scan_code),
    .scan_dav   (scan_dav),
    .scan_err   (scan_err)
  );

  always #20 mclk25 = ~mclk25;

  always @(posedge mclk25) cyc++;

  // Monitor: compare popped bytes against the scoreboard, count error pulses
  always @(negedge mclk25) begin
    if (scan_err === 1'b1) begin
      obs_err++;
      last_err_cyc = cyc;
      checks++;
      if (err_prev) begin
        errors++;
        $display("FAIL err_width: scan_err high for 2+ cycles at cyc %0d (required 1)", cyc);
      end
    end
    err_prev = (scan_err === 1'b1);
    if (scan_dav === 1'b1) begin
      if (!dav_prev) last_rise_cyc = cyc;
      dav_run++;
    end else begin
      if (dav_prev) last_run_len = dav_run;
      dav_run = 0;
    end
    dav_prev = (scan_dav === 1'b1);
    if (scan_dav === 1'b1 && do_read === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, required no byte", scan_code);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (scan_code !== e) begin
          errors++;
          $display("FAIL pop_byte: got %h, required %h", scan_code, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge mclk25);
    #2;
  endtask

  // Clock out the first n bits of a frame (bit 0 = start)
  task automatic send_bits(input logic [10:0] bits, input int n, input int half,
                           input logic glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitch && i > 0) begin
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(half - 13);
      end else begin
        wait_cyc(half);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(half);
      ps2_clk = 1'b1;
    end
  endtask

  // Reference model: odd parity, stop must be 1, queue holds at most Depth bytes
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                            input int half, input logic glitch);
    logic par;
    par = ~(^b) ^ par_flip;
    if (!par_flip && stop_bit) begin
      if (exp_q.size() < Depth) exp_q.push_back(b);
      else                      exp_err++;
    end else begin
      exp_err++;
    end
    send_bits({stop_bit, par, b, 1'b0}, 11, half, glitch);
    ps2_data = 1'b1;
    wait_cyc(60);
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    repeat (n) begin
      rd_man = 1'b1;
      wait_cyc(1);
      rd_man = 1'b0;
      wait_cyc(1);
    end
    chk("drain_empty", scan_dav, 1'b0);
    chk("drain_sb", exp_q.size(), 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    wait_cyc(3);
    chk("rst_dav", scan_dav, 1'b0);
    chk("rst_code", scan_code, 8'h00);
    chk("rst_err", scan_err, 1'b0);
    reset_in_n = 1'b1;
    wait_cyc(5);

    // Good 0x1C at 12.5 kHz with do_read tied to scan_dav
    rd_tie = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 1000, 1'b0);
    chk("dav_latency", last_rise_cyc - last_fall_cyc, DavLat);
    chk("dav_width", last_run_len, 1);
    chk("err_1c", obs_err, exp_err);
    chk("sb_1c", exp_q.size(), 0);

    // F0 then 1C with no reads
    rd_tie = 1'b0;
    send_frame(8'hF0, 1'b0, 1'b1, 40, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 40, 1'b0);
    chk("ovf_err", obs_err, exp_err);
    chk("hold_dav", scan_dav, 1'b1);
    chk("hold_head", scan_code, 8'hF0);
    drain();

    // Bad parity then good 0x12
    rd_tie = 1'b1;
    send_frame(8'h1C, 1'b1, 1'b1, 40, 1'b0);
    chk("par_err", obs_err, exp_err);
    chk("par_dav", scan_dav, 1'b0);
    send_frame(8'h12, 1'b0, 1'b1, 40, 1'b0);
    chk("sb_12", exp_q.size(), 0);

    // Short clock glitches between bits
    send_frame(8'h5A, 1'b0, 1'b1, 40, 1'b1);
    chk("glitch_err", obs_err, exp_err);
    chk("sb_5a", exp_q.size(), 0);

    // Timeout after start + 4 data bits
    send_bits({6'h3F, 5'b0110_0}, 5, 40, 1'b0);
    exp_err++;
    wait_cyc(5300);
    chk("tmo_err", obs_err, exp_err);
    checks++;
    if (last_err_cyc - last_fall_cyc < 5000 || last_err_cyc - last_fall_cyc > 5020) begin
      errors++;
      $display("FAIL tmo_time: err %0d cycles after last fall, required about 5010",
               last_err_cyc - last_fall_cyc);
    end
    send_frame(8'h29, 1'b0, 1'b1, 40, 1'b0);
    chk("sb_29", exp_q.size(), 0);

    // Reset mid-frame: no error, nothing received
    send_bits({2'b11, 1'b1, 8'hA5, 1'b0}, 4, 40, 1'b0);
    reset_in_n = 1'b0;
    wait_cyc(2);
    reset_in_n = 1'b1;
    wait_cyc(200);
    chk("midrst_err", obs_err, exp_err);
    chk("midrst_dav", scan_dav, 1'b0);

    // Randomised batches
    for (int bt = 0; bt < 5; bt++) begin
      rd_tie = 1'($urandom_range(0, 1));
      for (int f = 0; f < 3; f++) begin
        send_frame(8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0),
                   $urandom_range(20, 60), 1'b0);
      end
      chk("rnd_err", obs_err, exp_err);
      if (!rd_tie) drain();
      else         chk("rnd_sb", exp_q.size(), 0);
    end

    chk("final_err", obs_err, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
